// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester frame sequencer.
package manchester_pkg;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // Last preamble byte followed by the start-of-frame delimiter.
    localparam logic [15:0] SYNC_WORD_DEF = 16'hAAD5;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/manchester_sync_detect.sv
// 16-bit sliding window that hunts for the sync word on up to two bits per cycle.
module manchester_sync_detect
    import manchester_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_clear,
    input  logic       i_seed,
    input  logic       i_shift,
    input  logic [1:0] i_bits,
    input  logic [1:0] i_count,
    output logic       o_match,
    output logic       o_match_first
);

    logic [15:0]       r_window;
    logic [15:0]       w_win1;
    logic [15:0]       w_win2;
    logic [1:0]        w_step_bit;
    logic [1:0]        w_step_vld;
    logic [1:0][15:0]  w_win_step;
    logic [1:0]        w_hit;

    // With two bits in a cycle in_bits[1] is the earlier one.
    assign w_step_bit[0] = (i_count == 2'd2) ? i_bits[1] : i_bits[0];
    assign w_step_bit[1] = i_bits[0];
    assign w_step_vld[0] = (i_count == 2'd1) || (i_count == 2'd2);
    assign w_step_vld[1] = (i_count == 2'd2);

    assign w_win1 = {r_window[14:0], w_step_bit[0]};
    assign w_win2 = {w_win1[14:0], w_step_bit[1]};
    assign w_win_step[0] = w_win1;
    assign w_win_step[1] = w_win2;

    // Compare the window after each individual bit shift.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
        assign w_hit[gi] = w_step_vld[gi] && (w_win_step[gi] == SYNC_WORD);
    end

    assign o_match       = |w_hit;
    // Match on the earlier of two bits: the later bit belongs to the payload.
    assign o_match_first = w_hit[0] && w_step_vld[1];

    // Window update: clear, reload with a single leftover bit, or shift.
    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_window <= '0;
        end else if (i_seed) begin
            r_window <= {15'd0, i_bits[0]};
        end else if (i_shift) begin
            if (i_count == 2'd1) begin
                r_window <= w_win1;
            end else if (i_count == 2'd2) begin
                r_window <= w_win2;
            end
        end
    end

endmodule

// File: rtl/manchester_frame_ctrl.sv
// Frame sequencer: sync hunt, payload byte assembly, abort and decoder resync.
module manchester_frame_ctrl
    import manchester_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
    parameter int          FRAME_BYTES  = 4,
    parameter int          IDLE_TIMEOUT = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [1:0]          in_bits,
    input  logic [1:0]          in_count,
    input  logic                dec_err,
    output logic [BYTE_W-1:0]   m_tdata,
    output logic                m_tvalid,
    output logic                m_tlast,
    output logic                frame_done,
    output logic                frame_err,
    output logic                dec_resync,
    output logic                locked
);

    state_t             r_state, w_state_next;
    logic [BYTE_W-1:0]  r_asm, w_asm_next;
    logic [2:0]         r_bit_cnt, w_bit_cnt_next;
    logic [7:0]         r_byte_cnt, w_byte_cnt_next;
    logic [15:0]        r_idle_cnt, w_idle_next;
    logic [BYTE_W-1:0]  r_tdata, w_tdata_next;
    logic               r_tvalid, w_tvalid_next;
    logic               r_tlast, w_tlast_next;
    logic               r_frame_err, w_frame_err_next;
    logic               r_resync, w_resync_next;

    logic               w_win_clear, w_win_seed, w_win_shift;
    logic               w_match, w_match_first;
    logic               w_first_bit;
    logic [BYTE_W-1:0]  w_asm1, w_asm2;
    logic               w_done_first, w_done_second;
    logic [7:0]         w_byte_inc;
    logic               w_last;
    logic               w_idle_hit, w_abort;

    manchester_sync_detect #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk           (aclk),
        .srst          (areset),
        .i_clear       (w_win_clear),
        .i_seed        (w_win_seed),
        .i_shift       (w_win_shift),
        .i_bits        (in_bits),
        .i_count       (in_count),
        .o_match       (w_match),
        .o_match_first (w_match_first)
    );

    // Serialise up to two bits into the assembler; at most one byte completes.
    assign w_first_bit   = (in_count == 2'd2) ? in_bits[1] : in_bits[0];
    assign w_asm1        = {r_asm[BYTE_W-2:0], w_first_bit};
    assign w_asm2        = {w_asm1[BYTE_W-2:0], in_bits[0]};
    assign w_done_first  = ((in_count == 2'd1) || (in_count == 2'd2)) && (r_bit_cnt == 3'd7);
    assign w_done_second = (in_count == 2'd2) && (r_bit_cnt == 3'd6);
    assign w_byte_inc    = r_byte_cnt + 8'd1;
    assign w_last        = (w_byte_inc == 8'(FRAME_BYTES));
    assign w_idle_hit    = (in_count == 2'd0) && (r_idle_cnt >= 16'(IDLE_TIMEOUT - 1));
    assign w_abort       = dec_err || (in_count == 2'd3) || w_idle_hit;

    // Next-state, datapath and strobe decode.
    always_comb begin
        w_state_next     = r_state;
        w_asm_next       = r_asm;
        w_bit_cnt_next   = r_bit_cnt;
        w_byte_cnt_next  = r_byte_cnt;
        w_idle_next      = r_idle_cnt;
        w_tdata_next     = r_tdata;
        w_tvalid_next    = 1'b0;
        w_tlast_next     = 1'b0;
        w_frame_err_next = 1'b0;
        w_resync_next    = 1'b0;
        w_win_clear      = 1'b0;
        w_win_seed       = 1'b0;
        w_win_shift      = 1'b0;
        unique case (r_state)
            ST_HUNT: begin
                if (dec_err || (in_count == 2'd3)) begin
                    // Bad decode while hunting: restart the decoder, drop the window.
                    w_win_clear   = 1'b1;
                    w_resync_next = 1'b1;
                end else if (w_match) begin
                    w_state_next    = ST_PAYLOAD;
                    w_win_clear     = 1'b1;
                    w_byte_cnt_next = 8'd0;
                    w_idle_next     = 16'd0;
                    if (w_match_first) begin
                        w_asm_next     = {{(BYTE_W-1){1'b0}}, in_bits[0]};
                        w_bit_cnt_next = 3'd1;
                    end else begin
                        w_asm_next     = '0;
                        w_bit_cnt_next = 3'd0;
                    end
                end else begin
                    w_win_shift = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (w_abort) begin
                    w_state_next     = ST_HUNT;
                    w_asm_next       = '0;
                    w_bit_cnt_next   = 3'd0;
                    w_byte_cnt_next  = 8'd0;
                    w_idle_next      = 16'd0;
                    w_frame_err_next = 1'b1;
                    w_resync_next    = 1'b1;
                    w_win_clear      = 1'b1;
                end else if (in_count == 2'd0) begin
                    if (r_idle_cnt != 16'hFFFF) begin
                        w_idle_next = r_idle_cnt + 16'd1;
                    end
                end else begin
                    w_idle_next    = 16'd0;
                    w_asm_next     = (in_count == 2'd2) ? w_asm2 : w_asm1;
                    w_bit_cnt_next = r_bit_cnt + ((in_count == 2'd2) ? 3'd2 : 3'd1);
                    if (w_done_first || w_done_second) begin
                        w_tvalid_next   = 1'b1;
                        w_tdata_next    = w_done_first ? w_asm1 : w_asm2;
                        w_byte_cnt_next = w_byte_inc;
                        if (w_last) begin
                            w_tlast_next    = 1'b1;
                            w_state_next    = ST_HUNT;
                            w_asm_next      = '0;
                            w_bit_cnt_next  = 3'd0;
                            w_byte_cnt_next = 8'd0;
                            // A bit trailing the final byte starts the next hunt.
                            if ((in_count == 2'd2) && w_done_first) begin
                                w_win_seed = 1'b1;
                            end else begin
                                w_win_clear = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_HUNT;
            r_asm       <= '0;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 8'd0;
            r_idle_cnt  <= 16'd0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_frame_err <= 1'b0;
            r_resync    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_asm       <= w_asm_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_byte_cnt  <= w_byte_cnt_next;
            r_idle_cnt  <= w_idle_next;
            r_tdata     <= w_tdata_next;
            r_tvalid    <= w_tvalid_next;
            r_tlast     <= w_tlast_next;
            r_frame_err <= w_frame_err_next;
            r_resync    <= w_resync_next;
        end
    end

    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign frame_done = r_tlast;
    assign frame_err  = r_frame_err;
    assign dec_resync = r_resync;
    assign locked     = (r_state == ST_PAYLOAD);

endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// Directed bench for manchester_frame_ctrl: one task per scenario.
module tb_manchester_frame_ctrl;

    logic       aclk = 1'b0;
    logic       areset;
    logic [1:0] in_bits;
    logic [1:0] in_count;
    logic       dec_err;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, frame_done, frame_err, dec_resync, locked;

    manchester_frame_ctrl dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_bits    (in_bits),
        .in_count   (in_count),
        .dec_err    (dec_err),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .dec_resync (dec_resync),
        .locked     (locked)
    );

    always #5 aclk = ~aclk;

    localparam logic [55:0] FRAME    = 56'hAAAAD5AABBCCDD;
    localparam logic [39:0] TO_BB    = 40'hAAAAD5AABB;
    localparam logic [31:0] TO_AA    = 32'hAAAAD5AA;
    localparam logic [27:0] MID_BYTE = 28'hAAAAD5A;
    localparam logic [23:0] SYNC_ONLY = 24'hAAAAD5;
    localparam logic [19:0] SYNC_HEAD = 20'hAAAAD;

    logic [7:0] exp_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q_data [$];
    bit         q_last [$];
    bit         q_done [$];
    int         q_cyc  [$];
    int         err_cnt, resync_cnt, stray_cnt;

    // One input cycle; outputs sampled 1 time unit after the edge that took the inputs.
    task automatic step(input logic [1:0] cnt, input logic [1:0] bits, input logic err);
        in_count = cnt;
        in_bits  = bits;
        dec_err  = err;
        @(posedge aclk);
        #1;
        cyc++;
        if (m_tvalid) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
            q_done.push_back(frame_done);
            q_cyc.push_back(cyc);
            $display("cyc %0d: byte %02h last=%0b done=%0b", cyc, m_tdata, m_tlast, frame_done);
        end
        if ((m_tlast || frame_done) && !m_tvalid) stray_cnt++;
        if (frame_err) err_cnt++;
        if (dec_resync) resync_cnt++;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_done.delete();
        q_cyc.delete();
        err_cnt    = 0;
        resync_cnt = 0;
        stray_cnt  = 0;
    endtask

    // Send nbits of s (MSB first). mode 0: 2 bits/cycle; mode 1: in_count cycles 1,2,0,2.
    task automatic send_stream(input logic [127:0] s, input int nbits, input int mode);
        int pos;
        int ph;
        int want;
        pos = nbits - 1;
        ph  = 0;
        while (pos >= 0) begin
            if (mode == 0) want = 2;
            else want = (ph == 0) ? 1 : (ph == 2) ? 0 : 2;
            ph = (ph + 1) % 4;
            if (want > pos + 1) want = pos + 1;
            if (want == 0) begin
                step(2'd0, 2'b00, 1'b0);
            end else if (want == 1) begin
                step(2'd1, {1'b0, s[pos]}, 1'b0);
                pos -= 1;
            end else begin
                step(2'd2, {s[pos], s[pos-1]}, 1'b0);
                pos -= 2;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step(2'd0, 2'b00, 1'b0);
        step(2'd0, 2'b00, 1'b0);
        areset = 1'b0;
        n_checks++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %02h expected 00", m_tdata); end
        n_checks++; if ({m_tvalid, m_tlast, frame_done} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %03b expected 000", {m_tvalid, m_tlast, frame_done}); end
        n_checks++; if ({frame_err, dec_resync, locked} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %03b expected 000", {frame_err, dec_resync, locked}); end
        $display("test_reset done");
    endtask

    task automatic test_clean();
        int t0;
        int lat [4] = '{16, 20, 24, 28};
        clear_mon();
        t0 = cyc;
        send_stream({72'd0, FRAME}, 56, 0);
        idle(2);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL clean_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL clean_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i]); end
            n_checks++; if (q_last[i] !== (i == 3)) begin n_fail++; $display("FAIL clean_tlast%0d: got %0b expected %0b", i, q_last[i], (i == 3)); end
            n_checks++; if (q_done[i] !== (i == 3)) begin n_fail++; $display("FAIL clean_done%0d: got %0b expected %0b", i, q_done[i], (i == 3)); end
            n_checks++; if (q_cyc[i] - t0 != lat[i]) begin n_fail++; $display("FAIL clean_latency%0d: got %0d expected %0d", i, q_cyc[i] - t0, lat[i]); end
        end
        n_checks++; if (err_cnt != 0 || stray_cnt != 0) begin n_fail++; $display("FAIL clean_err: got err=%0d stray=%0d expected 0 0", err_cnt, stray_cnt); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clean_unlock: got %0b expected 0", locked); end
        $display("test_clean done");
    endtask

    task automatic test_misaligned();
        int t0;
        int lat [4] = '{17, 21, 25, 29};
        clear_mon();
        t0 = cyc;
        send_stream({71'd0, 1'b0, FRAME}, 57, 0);
        idle(2);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL misalign_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL misalign_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i]); end
            n_checks++; if (q_cyc[i] - t0 != lat[i]) begin n_fail++; $display("FAIL misalign_latency%0d: got %0d expected %0d", i, q_cyc[i] - t0, lat[i]); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL misalign_err: got %0d expected 0", err_cnt); end
        $display("test_misaligned done");
    endtask

    task automatic test_mixed_rate();
        int t0;
        int lat [4] = '{26, 32, 38, 45};
        clear_mon();
        t0 = cyc;
        send_stream({72'd0, FRAME}, 56, 1);
        idle(2);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL mixed_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL mixed_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i]); end
            n_checks++; if (q_cyc[i] - t0 != lat[i]) begin n_fail++; $display("FAIL mixed_latency%0d: got %0d expected %0d", i, q_cyc[i] - t0, lat[i]); end
            n_checks++; if (q_last[i] !== (i == 3)) begin n_fail++; $display("FAIL mixed_tlast%0d: got %0b expected %0b", i, q_last[i], (i == 3)); end
        end
        $display("test_mixed_rate done");
    endtask

    task automatic test_idle_abort();
        clear_mon();
        send_stream({88'd0, TO_BB}, 40, 0);
        idle(15);
        n_checks++; if (locked !== 1'b1 || err_cnt != 0) begin n_fail++; $display("FAIL idle_early: got locked=%0b err=%0d expected 1 0", locked, err_cnt); end
        idle(1);
        n_checks++; if (frame_err !== 1'b1 || dec_resync !== 1'b1) begin n_fail++; $display("FAIL idle_pulse: got err=%0b resync=%0b expected 1 1", frame_err, dec_resync); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL idle_unlock: got %0b expected 0", locked); end
        idle(3);
        n_checks++; if (err_cnt != 1 || resync_cnt != 1) begin n_fail++; $display("FAIL idle_once: got err=%0d resync=%0d expected 1 1", err_cnt, resync_cnt); end
        n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL idle_bytes: got %0d expected 2", q_data.size()); end
        clear_mon();
        send_stream({72'd0, FRAME}, 56, 0);
        idle(2);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL idle_next_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL idle_next_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i]); end
        end
        $display("test_idle_abort done");
    endtask

    task automatic test_dec_err();
        clear_mon();
        send_stream({100'd0, MID_BYTE}, 28, 0);
        step(2'd2, 2'b11, 1'b1);
        n_checks++; if (frame_err !== 1'b1 || dec_resync !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL decerr_abort: got err=%0b resync=%0b locked=%0b expected 1 1 0", frame_err, dec_resync, locked); end
        idle(3);
        n_checks++; if (q_data.size() != 0) begin n_fail++; $display("FAIL decerr_partial: got %0d bytes expected 0", q_data.size()); end
        // in_count==3 in PAYLOAD is treated as a decoder error.
        clear_mon();
        send_stream({104'd0, SYNC_ONLY}, 24, 0);
        step(2'd3, 2'b10, 1'b0);
        n_checks++; if (frame_err !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL count3_abort: got err=%0b locked=%0b expected 1 0", frame_err, locked); end
        // dec_err in HUNT splits a sync word: only a resync, and the window restarts.
        idle(2);
        clear_mon();
        send_stream({108'd0, SYNC_HEAD}, 20, 0);
        step(2'd0, 2'b00, 1'b1);
        n_checks++; if (dec_resync !== 1'b1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL hunt_err: got resync=%0b err=%0b expected 1 0", dec_resync, frame_err); end
        send_stream({124'd0, 4'h5}, 4, 0);
        idle(2);
        n_checks++; if (locked !== 1'b0 || err_cnt != 0 || resync_cnt != 1) begin n_fail++; $display("FAIL hunt_window: got locked=%0b err=%0d resync=%0d expected 0 0 1", locked, err_cnt, resync_cnt); end
        $display("test_dec_err done");
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_stream({96'd0, TO_AA}, 32, 0);
        n_checks++; if (q_data.size() != 1 || locked !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got bytes=%0d locked=%0b expected 1 1", q_data.size(), locked); end
        areset = 1'b1;
        step(2'd2, 2'b10, 1'b0);
        areset = 1'b0;
        n_checks++; if ({m_tdata, m_tvalid, m_tlast, frame_done, frame_err, dec_resync, locked} !== 14'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %0h expected 0", {m_tdata, m_tvalid, m_tlast, frame_done, frame_err, dec_resync, locked}); end
        clear_mon();
        send_stream({72'd0, FRAME}, 56, 0);
        idle(2);
        n_checks++; if (q_data.size() != 4 || err_cnt != 0) begin n_fail++; $display("FAIL rstmid_next: got bytes=%0d err=%0d expected 4 0", q_data.size(), err_cnt); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i]); end
        end
        $display("test_reset_mid_frame done");
    endtask

    // Final byte ends on in_bits[1]; the trailing bit is the next frame's first sync bit.
    task automatic test_back_to_back();
        clear_mon();
        send_stream({15'd0, 1'b0, FRAME, FRAME}, 113, 0);
        idle(2);
        n_checks++; if (q_data.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            n_checks++; if (q_data[i] !== exp_bytes[i % 4]) begin n_fail++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, q_data[i], exp_bytes[i % 4]); end
            n_checks++; if (q_last[i] !== ((i % 4) == 3)) begin n_fail++; $display("FAIL b2b_tlast%0d: got %0b expected %0b", i, q_last[i], ((i % 4) == 3)); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", err_cnt); end
        $display("test_back_to_back done");
    endtask

    initial begin
        areset   = 1'b1;
        in_bits  = 2'b00;
        in_count = 2'd0;
        dec_err  = 1'b0;
        clear_mon();
        test_reset();
        test_clean();
        test_misaligned();
        test_mixed_rate();
        test_idle_abort();
        test_dec_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
